id_scoreboard_hazard: RTL and testbench
=======================================

// Module: id_scoreboard_hazard
// PURPOSE
//  Parametrised load-use/long-latency hazard unit for the ID stage; replaces the fixed single-bubble
//  MemRead_ex comparator. Keeps a per-register countdown scoreboard of in-flight results and stalls
//  the instruction in ID until every source it actually reads can be forwarded. Sits beside the
//  register file/decoder in ID; drives Stall and IFWrite to IF, the IF/ID register and the ID/EX bubble mux.
// PARAMETERS
//  NUM_REGS  32  architectural registers; entry 0 (x0) is never scoreboarded
//  ADDR_W    5   register address width, $clog2(NUM_REGS)
//  LOAD_LAT  1   stall cycles a dependent needs behind a load (1 = classic single bubble); >=1
//  LONG_LAT  3   stall cycles behind a long-latency op (multi-cycle ALU/mul); >=1
//  CNT_W     2   counter width; must satisfy 2**CNT_W-1 >= max(LOAD_LAT,LONG_LAT)
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous reset, active-high
//  id_valid      in   1         ID holds a real (non-bubble) instruction
//  rs1Addr_id    in   ADDR_W    source 1 address of ID instruction
//  rs2Addr_id    in   ADDR_W    source 2 address of ID instruction
//  rs1_used      in   1         ID instruction reads rs1 (from Decode)
//  rs2_used      in   1         ID instruction reads rs2 (from Decode)
//  rdAddr_id     in   ADDR_W    destination of ID instruction
//  RegWrite_id   in   1         ID instruction writes rd
//  lat_class_id  in   2         0=ALU (forwardable next cycle), 1=load, 2=long, 3=reserved (treated as long)
//  flush         in   1         ID instruction squashed this cycle (taken branch/jump)
//  Stall         out  1         hold PC and IF/ID, insert bubble into ID/EX
//  IFWrite       out  1         ~Stall
//  busy_vec      out  NUM_REGS  bit r = cnt[r]!=0 (debug/visibility)
//  stall_cycles  out  32        saturating count of cycles with Stall=1
// BEHAVIOUR
//  - State: cnt[r] (CNT_W bits) for r=1..NUM_REGS-1; cnt[0] is hardwired 0.
//  - Stall (combinational from registered cnt + ID inputs) =
//    id_valid & ~flush & ((rs1_used & cnt[rs1Addr_id]!=0) | (rs2_used & cnt[rs2Addr_id]!=0)).
//    x0 sources never stall; unused sources never stall (no false rs2 stalls on I-type).
//  - issue = id_valid & ~Stall & ~flush & RegWrite_id & (rdAddr_id!=0) & (lat_class_id!=0).
//  - Every cycle each nonzero cnt[r] decrements by 1; zero stays zero (no wrap).
//  - On issue, cnt[rdAddr_id] <= LOAD_LAT (class 1) or LONG_LAT (class 2/3) on the next edge;
//    load takes priority over decrement of the same entry (WAW: newest producer wins).
//  - Class 0 issue to a busy rd leaves cnt unchanged (older long op's later write is still awaited;
//    conservative, ordered writeback is guaranteed by the pipeline).
//  - Latency: producer issued on edge N with LAT=L -> dependent in ID stalls cycles N+1..N+L,
//    advances at edge N+L+1. LOAD_LAT=1 reproduces the legacy one-bubble behaviour exactly.
//  - flush: suppresses Stall and issue for that cycle; does not clear existing entries (all issued
//    producers are older than the resolving branch).
//  - Simultaneous stall and flush: flush wins (Stall=0).
//  - stall_cycles increments each cycle Stall=1; saturates at 32'hFFFF_FFFF.
//  - Reset (any cycle, incl. mid-stall): all cnt=0, busy_vec=0, Stall=0, IFWrite=1, stall_cycles=0;
//    outputs take these values in the cycle after the rst edge and hold while rst=1.
//  - rst=1 masks issue.
// STRUCTURE
//  - Shared package: lat_class encodings (LAT_ALU=2'd0, LAT_LOAD=2'd1, LAT_LONG=2'd2), default
//    LOAD_LAT/LONG_LAT constants, CNT_W derivation function.
//  - One sub-module: sb_entry (one counter: load, decrement-to-zero, sync reset, busy out), generated
//    for r=1..NUM_REGS-1; top holds address match, stall logic and perf counter.
//  - Elaboration check: CNT_W wide enough, LOAD_LAT>=1, LONG_LAT>=1.
// TESTING
//  - Load x5 (class1, LOAD_LAT=1), next instr reads rs1=x5 -> Stall=1 exactly 1 cycle, IFWrite=0, then issue.
//  - LONG_LAT=3, long op writes x7, dependent rs2=x7 rs2_used=1 -> 3 stall cycles; stall_cycles=3.
//  - Load writes x0 / dependent reads x5 with rs1_used=0 / load to x5 then addi (class 0) reads x6 -> Stall=0 throughout.
//  - Busy x9 dependent in ID with flush=1 -> Stall=0, no issue; busy_vec[9] still counts down to 0.
//  - WAW: long op x4 (cnt=3), after 1 cycle load x4 issues -> cnt[4]=LOAD_LAT next cycle.
//  - Assert rst mid-stall with busy_vec=0x0000_0220 -> next cycle busy_vec=0, Stall=0, stall_cycles=0.

Source files
------------

// File: rtl/id_scoreboard_hazard_pkg.sv
// Shared definitions for the ID-stage scoreboard hazard unit: latency class
// encodings, default producer latencies and the counter-width helper.
package id_scoreboard_hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_LONG = 2'd2,
        LAT_RSVD = 2'd3
    } lat_class_e;

    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_LONG_LAT = 3;

    // Smallest counter width that can hold the larger of the two latencies.
    function automatic int cnt_w_for(input int load_lat, input int long_lat);
        int max_lat;
        max_lat = (load_lat > long_lat) ? load_lat : long_lat;
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/id_scoreboard_hazard_if.sv
// ID-stage hazard bundle: decoded source/destination info toward the hazard
// unit and the stall/visibility signals back toward IF and the pipeline regs.
interface id_scoreboard_hazard_if
    import id_scoreboard_hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
);
    logic                id_valid;
    logic [ADDR_W-1:0]   rs1Addr_id;
    logic [ADDR_W-1:0]   rs2Addr_id;
    logic                rs1_used;
    logic                rs2_used;
    logic [ADDR_W-1:0]   rdAddr_id;
    logic                RegWrite_id;
    lat_class_e          lat_class_id;
    logic                flush;
    logic                Stall;
    logic                IFWrite;
    logic [NUM_REGS-1:0] busy_vec;
    logic [31:0]         stall_cycles;

    modport master (
        output id_valid, rs1Addr_id, rs2Addr_id, rs1_used, rs2_used,
               rdAddr_id, RegWrite_id, lat_class_id, flush,
        input  Stall, IFWrite, busy_vec, stall_cycles
    );

    modport slave (
        input  id_valid, rs1Addr_id, rs2Addr_id, rs1_used, rs2_used,
               rdAddr_id, RegWrite_id, lat_class_id, flush,
        output Stall, IFWrite, busy_vec, stall_cycles
    );
endinterface

// File: rtl/id_scoreboard_hazard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until the pending result for a
// register becomes forwardable. A new producer overrides the running count.
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);
    logic [CNT_W-1:0] cnt_r;

    // Countdown register: newest producer wins over the decrement, stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/id_scoreboard_hazard.sv
// Load-use / long-latency hazard unit for ID: per-register countdown
// scoreboard, source match, stall generation and a saturating stall counter.
module id_scoreboard_hazard
    import id_scoreboard_hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int LONG_LAT = DEF_LONG_LAT,
    parameter int CNT_W    = cnt_w_for(LOAD_LAT, LONG_LAT)
) (
    input  logic                   clk,
    input  logic                   rst,
    id_scoreboard_hazard_if.slave  bus
);
    localparam int MAX_LAT = (LOAD_LAT > LONG_LAT) ? LOAD_LAT : LONG_LAT;

    if (((2 ** CNT_W) - 1) < MAX_LAT) begin : g_bad_cnt_w
        $error("id_scoreboard_hazard: CNT_W too narrow for the configured latencies");
    end
    if (LOAD_LAT < 1) begin : g_bad_load_lat
        $error("id_scoreboard_hazard: LOAD_LAT must be at least 1");
    end
    if (LONG_LAT < 1) begin : g_bad_long_lat
        $error("id_scoreboard_hazard: LONG_LAT must be at least 1");
    end

    logic [NUM_REGS-1:0] busy_s;
    logic                stall_s;
    logic                issue_s;
    logic [CNT_W-1:0]    load_val_s;
    logic [31:0]         stall_cycles_r;

    // x0 is never a real producer, so it can never be busy.
    assign busy_s[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic load_s;
        assign load_s = issue_s && (bus.rdAddr_id == ADDR_W'(r));
        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (load_s),
            .load_val (load_val_s),
            .busy     (busy_s[r])
        );
    end

    // Stall only on sources the instruction really reads; a squashed slot never stalls.
    always_comb begin
        stall_s = 1'b0;
        if (bus.id_valid && !bus.flush) begin
            stall_s = (bus.rs1_used && busy_s[bus.rs1Addr_id]) ||
                      (bus.rs2_used && busy_s[bus.rs2Addr_id]);
        end else begin
            stall_s = 1'b0;
        end
    end

    // Only non-ALU producers that actually advance out of ID need a scoreboard entry.
    always_comb begin
        issue_s = 1'b0;
        if (!rst && bus.id_valid && !bus.flush && !stall_s && bus.RegWrite_id &&
            (bus.rdAddr_id != {ADDR_W{1'b0}}) && (bus.lat_class_id != LAT_ALU)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Reserved class falls into the long-latency bucket.
    always_comb begin
        load_val_s = CNT_W'(LONG_LAT);
        case (bus.lat_class_id)
            LAT_LOAD: load_val_s = CNT_W'(LOAD_LAT);
            LAT_LONG: load_val_s = CNT_W'(LONG_LAT);
            default:  load_val_s = CNT_W'(LONG_LAT);
        endcase
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign bus.Stall        = stall_s;
    assign bus.IFWrite      = ~stall_s;
    assign bus.busy_vec     = busy_s;
    assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_id_scoreboard_hazard.sv
// Directed bench for id_scoreboard_hazard: each step drives one ID-stage
// cycle, queues the expected outputs and checks them before the next edge.
module tb_id_scoreboard_hazard;
    import id_scoreboard_hazard_pkg::*;

    typedef struct {
        logic        stall;
        logic [31:0] busy;
        logic [31:0] sc;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] exp_sc;
    exp_t sb_q[$];

    id_scoreboard_hazard_if #(.NUM_REGS(32), .ADDR_W(5)) bus ();

    id_scoreboard_hazard #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .LOAD_LAT (1),
        .LONG_LAT (3),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One ID cycle: drive at negedge, queue expectation, compare, then model the edge.
    task automatic step(input string tag, input bit r, input bit v,
                        input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit rw, input int cls, input bit fl,
                        input bit e_stall, input logic [31:0] e_busy);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.id_valid     = v;
        bus.rs1Addr_id   = rs1[4:0];
        bus.rs2Addr_id   = rs2[4:0];
        bus.rs1_used     = u1;
        bus.rs2_used     = u2;
        bus.rdAddr_id    = rd[4:0];
        bus.RegWrite_id  = rw;
        bus.lat_class_id = lat_class_e'(cls[1:0]);
        bus.flush        = fl;
        e.stall = e_stall;
        e.busy  = e_busy;
        e.sc    = exp_sc;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        chk({tag, ".stall"},   {31'd0, bus.Stall},   {31'd0, e.stall});
        chk({tag, ".ifwrite"}, {31'd0, bus.IFWrite}, {31'd0, ~e.stall});
        chk({tag, ".busy"},    bus.busy_vec,         e.busy);
        chk({tag, ".cycles"},  bus.stall_cycles,     e.sc);
        if (r) exp_sc = 32'd0;
        else if (e_stall) exp_sc = exp_sc + 32'd1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_sc = 32'd0;
        rst = 1'b1;
        bus.id_valid = 1'b0;
        bus.rs1Addr_id = 5'd0;
        bus.rs2Addr_id = 5'd0;
        bus.rs1_used = 1'b0;
        bus.rs2_used = 1'b0;
        bus.rdAddr_id = 5'd0;
        bus.RegWrite_id = 1'b0;
        bus.lat_class_id = LAT_ALU;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);

        //    tag        rst v rs1 rs2 u1 u2 rd rw cls fl   stall busy
        step("reset",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1'b0, 32'h0000_0000);
        // load x5 then dependent on rs1: exactly one bubble
        step("ld5",      0, 1, 0, 0, 0, 0, 5, 1, 1, 0,   1'b0, 32'h0000_0000);
        step("use5_a",   0, 1, 5, 0, 1, 0, 6, 1, 0, 0,   1'b1, 32'h0000_0020);
        step("use5_b",   0, 1, 5, 0, 1, 0, 6, 1, 0, 0,   1'b0, 32'h0000_0000);
        // long op x7 then dependent on rs2: three bubbles
        step("long7",    0, 1, 0, 0, 0, 0, 7, 1, 2, 0,   1'b0, 32'h0000_0000);
        step("use7_a",   0, 1, 0, 7, 1, 1, 8, 1, 0, 0,   1'b1, 32'h0000_0080);
        step("use7_b",   0, 1, 0, 7, 1, 1, 8, 1, 0, 0,   1'b1, 32'h0000_0080);
        step("use7_c",   0, 1, 0, 7, 1, 1, 8, 1, 0, 0,   1'b1, 32'h0000_0080);
        step("use7_d",   0, 1, 0, 7, 1, 1, 8, 1, 0, 0,   1'b0, 32'h0000_0000);
        // no false stalls: x0 destination/source, unused sources, unrelated reader
        step("ld0",      0, 1, 0, 0, 0, 0, 0, 1, 1, 0,   1'b0, 32'h0000_0000);
        step("rdx0",     0, 1, 0, 0, 1, 1, 5, 1, 1, 0,   1'b0, 32'h0000_0000);
        step("unused5",  0, 1, 5, 5, 0, 0, 0, 0, 0, 0,   1'b0, 32'h0000_0020);
        step("ld5b",     0, 1, 0, 0, 0, 0, 5, 1, 1, 0,   1'b0, 32'h0000_0000);
        step("addi6",    0, 1, 6, 0, 1, 0, 10, 1, 0, 0,  1'b0, 32'h0000_0020);
        // flush over a busy source: no stall, no issue, entry keeps counting
        step("long9",    0, 1, 0, 0, 0, 0, 9, 1, 2, 0,   1'b0, 32'h0000_0000);
        step("fl9_a",    0, 1, 9, 0, 1, 0, 11, 1, 1, 1,  1'b0, 32'h0000_0200);
        step("fl9_b",    0, 1, 9, 0, 1, 0, 11, 1, 1, 1,  1'b0, 32'h0000_0200);
        step("fl9_c",    0, 1, 9, 0, 1, 0, 11, 1, 1, 1,  1'b0, 32'h0000_0200);
        step("fl9_d",    0, 0, 11, 0, 1, 0, 0, 0, 0, 0,  1'b0, 32'h0000_0000);
        // WAW: load to x4 one cycle behind a long op to x4 shortens the wait
        step("long4",    0, 1, 0, 0, 0, 0, 4, 1, 2, 0,   1'b0, 32'h0000_0000);
        step("ld4",      0, 1, 0, 0, 0, 0, 4, 1, 1, 0,   1'b0, 32'h0000_0010);
        step("use4_a",   0, 1, 4, 0, 1, 0, 0, 0, 0, 0,   1'b1, 32'h0000_0010);
        step("use4_b",   0, 1, 4, 0, 1, 0, 0, 0, 0, 0,   1'b0, 32'h0000_0000);
        // reserved class as long on x9, load x5, then reset mid-stall
        step("rsvd9",    0, 1, 0, 0, 0, 0, 9, 1, 3, 0,   1'b0, 32'h0000_0000);
        step("ld5c",     0, 1, 0, 0, 0, 0, 5, 1, 1, 0,   1'b0, 32'h0000_0200);
        step("rst_mid",  1, 1, 9, 0, 1, 0, 12, 1, 0, 0,  1'b1, 32'h0000_0220);
        step("rst_hold", 1, 1, 9, 0, 1, 0, 13, 1, 1, 0,  1'b0, 32'h0000_0000);
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1'b0, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
